// File: rtl/datapath_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | datapath_pkg: opcodes, flag bit positions and widths for the datapath |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
package datapath_pkg;

  localparam int WIDTH  = 16;
  localparam int NFLAGS = 5;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_LSH  = 8'h04;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ADDU = 8'h06;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_MOV  = 8'h0D;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_F = 2;
  localparam int FLG_L = 3;
  localparam int FLG_C = 4;

  typedef logic [NFLAGS-1:0] flags_t;

endpackage
`default_nettype wire

// File: rtl/datapath_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | datapath_alu: combinational ALU producing result, flag values, flag  |
// | update mask and a register-write qualifier.   Revision: 1.0           |
// +----------------------------------------------------------------------+
module datapath_alu #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [7:0]       alu_op_i,
  output logic [WIDTH-1:0] result_o,
  output logic [4:0]       flag_next_o,
  output logic [4:0]       flag_mask_o,
  output logic             wr_ok_o
);
  import datapath_pkg::*;

  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [4:0]       shamt_w;
  logic [4:0]       rmag_w;
  logic [WIDTH-1:0] lsh_w;
  logic             ovf_add_w;
  logic             ovf_sub_w;
  logic             lt_signed_w;

  assign sum_w  = {1'b0, a_i} + {1'b0, b_i};
  assign diff_w = {1'b0, a_i} - {1'b0, b_i};

  // Shift amount is a 5-bit two's-complement value: positive = left, negative = logical right
  assign shamt_w = b_i[4:0];
  assign rmag_w  = 5'd0 - b_i[4:0];

  always_comb begin
    lsh_w = '0;
    if (!shamt_w[4]) begin
      lsh_w = a_i << shamt_w[3:0];
    end else if (!rmag_w[4]) begin
      lsh_w = a_i >> rmag_w[3:0];
    end
  end

  assign ovf_add_w   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_w[WIDTH-1] != a_i[WIDTH-1]);
  assign ovf_sub_w   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff_w[WIDTH-1] != a_i[WIDTH-1]);
  assign lt_signed_w = diff_w[WIDTH-1] ^ ovf_sub_w;

  always_comb begin
    result_o    = '0;
    flag_next_o = '0;
    flag_mask_o = '0;
    wr_ok_o     = 1'b0;
    case (alu_op_i)
      OP_AND: begin
        result_o = a_i & b_i;
        wr_ok_o  = 1'b1;
        flag_mask_o[FLG_Z] = 1'b1;
        flag_mask_o[FLG_N] = 1'b1;
      end
      OP_OR: begin
        result_o = a_i | b_i;
        wr_ok_o  = 1'b1;
        flag_mask_o[FLG_Z] = 1'b1;
        flag_mask_o[FLG_N] = 1'b1;
      end
      OP_XOR: begin
        result_o = a_i ^ b_i;
        wr_ok_o  = 1'b1;
        flag_mask_o[FLG_Z] = 1'b1;
        flag_mask_o[FLG_N] = 1'b1;
      end
      OP_LSH: begin
        result_o = lsh_w;
        wr_ok_o  = 1'b1;
        flag_mask_o[FLG_Z] = 1'b1;
        flag_mask_o[FLG_N] = 1'b1;
      end
      OP_ADD: begin
        result_o = sum_w[WIDTH-1:0];
        wr_ok_o  = 1'b1;
        flag_next_o[FLG_C] = sum_w[WIDTH];
        flag_next_o[FLG_F] = ovf_add_w;
        flag_mask_o[FLG_C] = 1'b1;
        flag_mask_o[FLG_F] = 1'b1;
        flag_mask_o[FLG_Z] = 1'b1;
        flag_mask_o[FLG_N] = 1'b1;
      end
      OP_ADDU: begin
        result_o = sum_w[WIDTH-1:0];
        wr_ok_o  = 1'b1;
        flag_next_o[FLG_C] = sum_w[WIDTH];
        flag_mask_o[FLG_C] = 1'b1;
        flag_mask_o[FLG_Z] = 1'b1;
        flag_mask_o[FLG_N] = 1'b1;
      end
      OP_SUB: begin
        result_o = diff_w[WIDTH-1:0];
        wr_ok_o  = 1'b1;
        flag_next_o[FLG_C] = diff_w[WIDTH];
        flag_next_o[FLG_F] = ovf_sub_w;
        flag_mask_o[FLG_C] = 1'b1;
        flag_mask_o[FLG_F] = 1'b1;
        flag_mask_o[FLG_Z] = 1'b1;
        flag_mask_o[FLG_N] = 1'b1;
      end
      OP_CMP: begin
        result_o = diff_w[WIDTH-1:0];
        flag_mask_o[FLG_Z] = 1'b1;
        flag_mask_o[FLG_N] = 1'b1;
        flag_mask_o[FLG_L] = 1'b1;
      end
      OP_MOV: begin
        result_o = b_i;
        wr_ok_o  = 1'b1;
      end
      default: begin
        result_o = '0;
      end
    endcase

    // CMP defines its own Z/N; every other op derives them from the result
    if (alu_op_i == OP_CMP) begin
      flag_next_o[FLG_Z] = (a_i == b_i);
      flag_next_o[FLG_N] = lt_signed_w;
      flag_next_o[FLG_L] = diff_w[WIDTH];
    end else begin
      flag_next_o[FLG_Z] = ~|result_o;
      flag_next_o[FLG_N] = result_o[WIDTH-1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_alu_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_alu_datapath: register file, operand muxes, ALU, flag reg and |
// | result bus with a combinational display read port.   Revision: 1.0   |
// +----------------------------------------------------------------------+
module regfile_alu_datapath #(
  parameter int WIDTH = 16,
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       alu_op,
  input  logic [4:0]       muxA,
  input  logic [4:0]       muxB,
  input  logic [WIDTH-1:0] imm,
  input  logic             imm_control,
  input  logic [NREGS-1:0] regs_en,
  input  logic             buff_en,
  output logic [WIDTH-1:0] bus_out,
  output logic [4:0]       flags,
  input  logic [3:0]       disp_sel,
  output logic [WIDTH-1:0] disp_data
);
  import datapath_pkg::*;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [4:0]       flags_q;
  logic [4:0]       flags_d;

  logic [WIDTH-1:0] op_a_w;
  logic [WIDTH-1:0] op_b_w;
  logic [WIDTH-1:0] result_w;
  logic [4:0]       flag_next_w;
  logic [4:0]       flag_mask_w;
  logic             wr_ok_w;
  logic             wr_en_w;

  assign op_a_w = muxA[4] ? '0 : regs_q[muxA[3:0]];
  assign op_b_w = imm_control ? imm : (muxB[4] ? '0 : regs_q[muxB[3:0]]);

  datapath_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a_i         (op_a_w),
    .b_i         (op_b_w),
    .alu_op_i    (alu_op),
    .result_o    (result_w),
    .flag_next_o (flag_next_w),
    .flag_mask_o (flag_mask_w),
    .wr_ok_o     (wr_ok_w)
  );

  assign bus_out = buff_en ? result_w : '0;
  assign wr_en_w = buff_en & wr_ok_w;

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NREGS; i++) begin
      if (wr_en_w && regs_en[i]) begin
        regs_d[i] = result_w;
      end
    end
  end

  // Only the flags named in the mask move; the rest keep their value
  always_comb begin
    flags_d = flags_q;
    if (buff_en) begin
      flags_d = (flags_q & ~flag_mask_w) | (flag_next_w & flag_mask_w);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      flags_q <= '0;
    end else begin
      regs_q  <= regs_d;
      flags_q <= flags_d;
    end
  end

  assign flags     = flags_q;
  assign disp_data = regs_q[disp_sel];

endmodule
`default_nettype wire

// File: tb/tb_regfile_alu_datapath.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_regfile_alu_datapath: directed and random stimulus against an      |
// | arithmetic reference model of the datapath.   Revision: 1.0           |
// +----------------------------------------------------------------------+
module tb_regfile_alu_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  alu_op;
  logic [4:0]  muxA;
  logic [4:0]  muxB;
  logic [15:0] imm;
  logic        imm_control;
  logic [15:0] regs_en;
  logic        buff_en;
  logic [15:0] bus_out;
  logic [4:0]  flags;
  logic [3:0]  disp_sel;
  logic [15:0] disp_data;

  int checks   = 0;
  int failures = 0;

  int unsigned m_regs [16];
  bit m_c, m_l, m_f, m_n, m_z;

  always #5 clk = ~clk;

  regfile_alu_datapath #(
    .WIDTH (16),
    .NREGS (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .alu_op      (alu_op),
    .muxA        (muxA),
    .muxB        (muxB),
    .imm         (imm),
    .imm_control (imm_control),
    .regs_en     (regs_en),
    .buff_en     (buff_en),
    .bus_out     (bus_out),
    .flags       (flags),
    .disp_sel    (disp_sel),
    .disp_data   (disp_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic int sx(input int unsigned v);
    return (v >= 32768) ? int'(v) - 65536 : int'(v);
  endfunction

  function automatic bit is_writer(input int op);
    return op inside {1, 2, 3, 4, 5, 6, 9, 13};
  endfunction

  function automatic int unsigned model_result(input int op, input int unsigned a, input int unsigned b);
    int s;
    case (op)
      1: return a & b;
      2: return a | b;
      3: return a ^ b;
      4: begin
        s = int'(b % 32);
        if (s >= 16) s -= 32;
        if (s >= 0) return (a << s) % 65536;
        if (-s >= 16) return 0;
        return a >> (-s);
      end
      5, 6: return (a + b) % 65536;
      9, 11: return (a + 65536 - b) % 65536;
      13: return b;
      default: return 0;
    endcase
  endfunction

  function automatic void model_commit(input int op, input int unsigned a, input int unsigned b,
                                       input int unsigned res, input logic [15:0] en, input logic buff);
    int ss;
    if (!buff) return;
    if (is_writer(op)) begin
      for (int i = 0; i < 16; i++) if (en[i]) m_regs[i] = res;
    end
    if (op inside {1, 2, 3, 4, 5, 6, 9}) begin
      m_z = (res == 0);
      m_n = (res >= 32768);
    end
    if (op == 5 || op == 6) m_c = (a + b) > 65535;
    if (op == 5) begin
      ss  = sx(a) + sx(b);
      m_f = (ss > 32767) || (ss < -32768);
    end
    if (op == 9) begin
      ss  = sx(a) - sx(b);
      m_c = a < b;
      m_f = (ss > 32767) || (ss < -32768);
    end
    if (op == 11) begin
      m_z = (a == b);
      m_n = sx(a) < sx(b);
      m_l = a < b;
    end
  endfunction

  function automatic logic [4:0] exp_flags();
    return {m_c, m_l, m_f, m_n, m_z};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 0;
    {m_c, m_l, m_f, m_n, m_z} = 5'b0;
  endtask

  task automatic idle();
    alu_op = 8'h00; regs_en = 16'h0; buff_en = 1'b0; imm_control = 1'b0;
  endtask

  // Entered and left on a negedge
  task automatic apply_op(input int op, input logic [4:0] ma, input logic [4:0] mb, input logic [15:0] im,
                          input logic ictl, input logic [15:0] en, input logic buff, input string tag);
    int unsigned a, b, res;
    logic [3:0] ds;
    a   = ma[4] ? 0 : m_regs[ma[3:0]];
    b   = ictl ? 32'(im) : (mb[4] ? 0 : m_regs[mb[3:0]]);
    res = model_result(op, a, b);
    ds  = 4'($urandom_range(0, 15));
    alu_op = 8'(op); muxA = ma; muxB = mb; imm = im; imm_control = ictl;
    regs_en = en; buff_en = buff; disp_sel = ds;
    #1;
    if (op != 11 || !buff) check({tag, "_bus"}, bus_out, buff ? res : 0);
    check({tag, "_rdold"}, disp_data, m_regs[ds]);
    @(posedge clk);
    model_commit(op, a, b, res, en, buff);
    #1;
    check({tag, "_flags"}, flags, exp_flags());
    check({tag, "_rdnew"}, disp_data, m_regs[ds]);
    @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    idle();
    for (int i = 0; i < 16; i++) begin
      disp_sel = 4'(i);
      #1;
      check($sformatf("%s_r%0d", tag, i), disp_data, m_regs[i]);
    end
    check({tag, "_flags"}, flags, exp_flags());
    @(negedge clk);
  endtask

  task automatic mov_reg(input int idx, input logic [15:0] val);
    apply_op(13, 5'h10, 5'h10, val, 1'b1, 16'(1 << idx), 1'b1, "mov");
  endtask

  task automatic show_reg(input int idx, input logic [15:0] expv, input string tag);
    idle();
    disp_sel = 4'(idx);
    #1;
    check(tag, disp_data, expv);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned fib_exp [5] = '{1, 1, 2, 3, 5};
    int ops [13] = '{0, 1, 2, 3, 4, 5, 6, 9, 11, 13, 7, 10, 255};
    int op;
    logic [4:0] ma, mb;
    logic [15:0] en;

    model_reset();
    reset = 1'b0; alu_op = 8'h0D; muxA = 5'h0; muxB = 5'h0; imm = 16'h1234;
    imm_control = 1'b1; regs_en = 16'hFFFF; buff_en = 1'b0; disp_sel = 4'h0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_bus", bus_out, 16'h0);
    check("rst_flags", flags, 5'h0);
    check_all("rst");
    reset = 1'b1;

    // Fibonacci R1..R5
    apply_op(5, 5'd1, 5'd0, 16'd1, 1'b1, 16'h0002, 1'b1, "fib1");
    apply_op(5, 5'd1, 5'd0, 16'd0, 1'b0, 16'h0004, 1'b1, "fib2");
    apply_op(5, 5'd1, 5'd2, 16'd0, 1'b0, 16'h0008, 1'b1, "fib3");
    apply_op(5, 5'd2, 5'd3, 16'd0, 1'b0, 16'h0010, 1'b1, "fib4");
    apply_op(5, 5'd3, 5'd4, 16'd0, 1'b0, 16'h0020, 1'b1, "fib5");
    for (int i = 0; i < 5; i++) show_reg(i + 1, 16'(fib_exp[i]), $sformatf("fib_r%0d", i + 1));

    // Multi-hot write
    apply_op(13, 5'h10, 5'h10, 16'h00AA, 1'b1, 16'h0006, 1'b1, "mov2");
    show_reg(1, 16'h00AA, "mov2_r1");
    show_reg(2, 16'h00AA, "mov2_r2");
    show_reg(3, 16'h0002, "mov2_r3");
    check_all("mov2");

    // Signed overflow and carry
    mov_reg(6, 16'h7FFF);
    apply_op(5, 5'd6, 5'd0, 16'd1, 1'b1, 16'h0000, 1'b1, "ovf");
    check("ovf_bus", bus_out, 16'h8000);
    check("ovf_F", flags[2], 1'b1);
    check("ovf_C", flags[4], 1'b0);
    check("ovf_N", flags[1], 1'b1);
    mov_reg(6, 16'hFFFF);
    apply_op(5, 5'd6, 5'd0, 16'd1, 1'b1, 16'h0000, 1'b1, "carry");
    check("carry_bus", bus_out, 16'h0000);
    check("carry_C", flags[4], 1'b1);
    check("carry_Z", flags[0], 1'b1);

    // Compare does not write even with all enables set
    mov_reg(1, 16'd3);
    apply_op(11, 5'd1, 5'd0, 16'd5, 1'b1, 16'hFFFF, 1'b1, "cmp35");
    check("cmp35_L", flags[3], 1'b1);
    check("cmp35_N", flags[1], 1'b1);
    check("cmp35_Z", flags[0], 1'b0);
    show_reg(1, 16'd3, "cmp35_r1");
    mov_reg(1, 16'd5);
    apply_op(11, 5'd1, 5'd0, 16'd5, 1'b1, 16'hFFFF, 1'b1, "cmp55");
    check("cmp55_Z", flags[0], 1'b1);
    check("cmp55_L", flags[3], 1'b0);

    // Bus disabled: no writes, flags hold
    apply_op(13, 5'h10, 5'h10, 16'h1234, 1'b1, 16'hFFFF, 1'b0, "nobuf");
    check("nobuf_bus", bus_out, 16'h0);
    check_all("nobuf");

    // Shifter boundaries
    mov_reg(7, 16'h1234);
    apply_op(4, 5'd7, 5'd0, 16'hFFE4, 1'b1, 16'h0100, 1'b1, "lsh_l4");
    check("lsh_l4_bus", bus_out, 16'h2340);
    apply_op(4, 5'd7, 5'd0, 16'h001C, 1'b1, 16'h0100, 1'b1, "lsh_r4");
    check("lsh_r4_bus", bus_out, 16'h0123);
    apply_op(4, 5'd7, 5'd0, 16'h000F, 1'b1, 16'h0100, 1'b1, "lsh_l15");
    apply_op(4, 5'd7, 5'd0, 16'h0010, 1'b1, 16'h0100, 1'b1, "lsh_r16");
    check("lsh_r16_bus", bus_out, 16'h0000);
    apply_op(4, 5'd7, 5'd0, 16'h0011, 1'b1, 16'h0100, 1'b1, "lsh_r15");
    apply_op(4, 5'd7, 5'd0, 16'h0000, 1'b1, 16'h0100, 1'b1, "lsh_0");

    // Random traffic
    for (int it = 0; it < 300; it++) begin
      op = ops[$urandom_range(0, 12)];
      ma = {($urandom_range(0, 7) == 0), 4'($urandom)};
      mb = {($urandom_range(0, 7) == 0), 4'($urandom)};
      case ($urandom_range(0, 3))
        0:       en = 16'h0;
        3:       en = 16'($urandom);
        default: en = 16'(1 << $urandom_range(0, 15));
      endcase
      apply_op(op, ma, mb, 16'($urandom), 1'($urandom_range(0, 1)), en,
               ($urandom_range(0, 7) != 0), $sformatf("rnd%0d", it));
      if (it % 50 == 49) check_all($sformatf("rndsweep%0d", it));
    end

    // Reset asserted between edges with a write pending
    for (int i = 1; i <= 5; i++) mov_reg(i, 16'(i * 17));
    apply_op(9, 5'd1, 5'd2, 16'd0, 1'b0, 16'h0000, 1'b1, "presub");
    alu_op = 8'h0D; imm = 16'h5555; imm_control = 1'b1; regs_en = 16'hFFFF;
    buff_en = 1'b1; disp_sel = 4'd1;
    #2;
    reset = 1'b0;
    #1;
    check("rstmid_flags", flags, 5'h0);
    check("rstmid_r1", disp_data, 16'h0);
    model_reset();
    @(negedge clk);
    check_all("rstmid");
    reset = 1'b1;
    apply_op(5, 5'h10, 5'd3, 16'd7, 1'b1, 16'h0008, 1'b1, "zeroA");
    check("zeroA_bus", bus_out, 16'd7);
    check_all("post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
